// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARM controller: FSM sequencing, NZCV flags, condition gating.
// Ports: CLK/RST, Op/Func/Cond, ALUFlags, MemReady in; memory, datapath
// muxes/enables and Status out. Optional macro MC_CTRL_MEMWAIT_EN enables
// the MemReady wait handshake (undefined: MemReady treated as constant 1).
module multi_cycle_controller #(
    parameter logic [3:0] STATUS_INIT = 4'b0000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] Op,
    input  logic [5:0] Func,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Status
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_condexq;
    logic [3:0] r_status;

    logic       w_ready;
    logic       w_condex;
    logic       w_nowrite;
    logic [3:0] w_cmd;
    logic [1:0] w_alu_dp;
    logic       w_memreq;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_regwrite;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;

    assign w_cmd     = Func[4:1];
    assign w_nowrite = (w_cmd == 4'b1010);
    assign {w_n, w_z, w_c, w_v} = r_status;

`ifdef MC_CTRL_MEMWAIT_EN
    assign w_ready = MemReady;
`else
    logic w_unused_ready;
    assign w_unused_ready = MemReady;
    assign w_ready        = 1'b1;
`endif

    // ARM condition evaluation against the current flags
    always_comb begin
        w_condex = 1'b0;
        unique case (Cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = ~w_z & w_c;
            4'b1001: w_condex = w_z | ~w_c;
            4'b1010: w_condex = ~(w_n ^ w_v);
            4'b1011: w_condex = w_n ^ w_v;
            4'b1100: w_condex = ~w_z & ~(w_n ^ w_v);
            4'b1101: w_condex = w_z | (w_n ^ w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // Data-processing command to ALU operation
    always_comb begin
        w_alu_dp = 2'b00;
        unique case (w_cmd)
            4'b0100: w_alu_dp = 2'b00;
            4'b0010: w_alu_dp = 2'b01;
            4'b1010: w_alu_dp = 2'b01;
            4'b0000: w_alu_dp = 2'b10;
            4'b1100: w_alu_dp = 2'b11;
            default: w_alu_dp = 2'b00;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Condition latch and NZCV register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_condexq <= 1'b0;
            r_status  <= STATUS_INIT;
        end else begin
            if (r_state == S_DECODE) begin
                r_condexq <= w_condex;
            end
            // C/V are only meaningful for arithmetic ops
            if ((r_state == S_EXECR || r_state == S_EXECI)
                && Func[0] && r_condexq) begin
                r_status[3:2] <= ALUFlags[3:2];
                if (w_alu_dp == 2'b00 || w_alu_dp == 2'b01) begin
                    r_status[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (Op)
                    2'b00:   w_next = Func[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_MEMADR: w_next = Func[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  begin
                // A squashed store skips the handshake entirely
                if (r_condexq && !w_ready) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        unique case (r_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = w_ready;
                w_pcwrite = w_ready;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_EXECR: begin
                ALUControl = w_alu_dp;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dp;
            end
            S_ALUWB: begin
                w_regwrite = r_condexq & ~w_nowrite;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = r_condexq;
            end
            S_MEMWR: begin
                w_memreq   = r_condexq;
                w_memwrite = r_condexq;
                AdrSrc     = r_condexq;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = r_condexq;
            end
            default: begin
                w_memreq = 1'b0;
            end
        endcase
    end

    // Reset kills any in-flight access or write immediately
    assign MemReq   = w_memreq & ~RST;
    assign MemWrite = w_memwrite & ~RST;
    assign IRWrite  = w_irwrite & ~RST;
    assign PCWrite  = w_pcwrite & ~RST;
    assign RegWrite = w_regwrite & ~RST;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign Status = r_status;

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Finite-state controller that sequences the shared multi-cycle ARM datapath (one memory port, one ALU, instruction register, ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps. It holds the NZCV status register and evaluates condition codes. It gates every architectural write with the latched condition result. It handshakes with instruction/data memory so that slow memory stalls the sequence.

## Interface
- STATUS_INIT, 4'b0000, NZCV value loaded on reset
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- Op  in  2  instruction [27:26]
- Func  in  6  instruction [25:20]: Func[5]=I, Func[4:1]=cmd, Func[0]=S (L for memory ops)
- Cond  in  4  instruction [31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, valid in execute states
- MemReady  in  1  memory completed the current access this cycle
- MemReq  out  1  memory access request; held until MemReady
- MemWrite  out  1  store strobe, qualifies MemReq
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals Op
- RegSrc  out  2  {Op==01, Op==10}
- Status  out  4  current NZCV, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Only listed outputs are non-zero. ALUControl defaults to ADD.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=MemReady. Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latches CondExQ = CondEx(Cond, Status).
  - Next state by Op: 00 goes to EXECI if Func[5], else EXECR. 01 goes to MEMADR. 10 goes to BRANCH. 11 (undefined) goes to FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 / 01. ALUControl from cmd: 0100 ADD, 0010 SUB, 1010 (CMP) SUB, 0000 AND, 1100 ORR, others ADD. Next state is ALUWB.
- ALUWB: ResultSrc=00. RegWrite = CondExQ & !NoWrite, where NoWrite = (cmd==1010). Next state is FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next is MEMRD if Func[0], else MEMWR.
- MEMRD: MemReq=1, AdrSrc=1. Waits for MemReady, then goes to MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExQ, then FETCH.
- MEMWR: if CondExQ, MemReq=MemWrite=1, AdrSrc=1, and the state waits for MemReady before going to FETCH. If !CondExQ, no request is made and the next state is FETCH immediately.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondExQ. Next state is FETCH.
- CondEx table (ARM): EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI !Z&C, LS Z|!C, GE !(N^V), LT N^V, GT !Z&!(N^V), LE Z|(N^V), AL 1, 1111 0.
- Flags: on the clock edge leaving EXECR/EXECI, when Func[0] & CondExQ:
  - Status[3:2] <= ALUFlags[3:2].
  - Status[1:0] <= ALUFlags[1:0] only when ALUControl is ADD or SUB.

## Timing
- While RST is high: state=FETCH, Status=STATUS_INIT, CondExQ=0. All write enables (IRWrite, PCWrite, RegWrite, MemWrite) and MemReq are forced to 0.
- After RST is released, the first MemReq asserts in the same cycle.
- Cycle counts with zero wait states:
  - Data processing: 4 (FETCH, DECODE, EXEC, ALUWB).
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each cycle MemReady is low adds one cycle to FETCH, MEMRD or MEMWR. Outputs are held constant during the wait.
- MemReady is ignored in every state other than FETCH, MEMRD and MEMWR.
- Condition gating uses CondExQ, so an instruction's own flag update never affects its own writeback.
- Asserting RST mid-access (FETCH wait, MEMRD, MEMWR) aborts the access immediately. No partial write is issued.

## Configuration
- MC_CTRL_MEMWAIT_EN defined: MemReady handshake is honoured as described above.
- MC_CTRL_MEMWAIT_EN undefined: MemReady is ignored and treated as constant 1. Every memory state lasts exactly one cycle. MemReq is still driven.

## Test plan
- Reset: RST=1 mid-MEMRD → state FETCH, Status=STATUS_INIT, RegWrite=MemWrite=PCWrite=0. On release, MemReq=1 in the same cycle.
- ADDS R1,R2,R3 with ALUFlags=0110, MemReady tied 1 → 4 cycles. RegWrite=1 in ALUWB only. Status=0110 after the EXEC edge.
- CMP then BEQ, with CMP setting Z=1 → CMP produces no RegWrite. BEQ asserts PCWrite in BRANCH and takes 3 cycles.
- STRNE with Z=1 → MEMWR issues no MemReq, and MEMWR lasts 1 cycle.
- LDR with MemReady low for 3 cycles in MEMRD → load takes 8 cycles, outputs stable during the wait, RegWrite=1 only in MEMWB. With MC_CTRL_MEMWAIT_EN undefined, the same stimulus takes 5 cycles.
- Op=11 → DECODE returns to FETCH with no writes. Cond=1111 on ADD → RegWrite=0 and Status unchanged.
